// File: rtl/alu_write_arbiter.sv
// rtl/alu_write_arbiter.sv - round-robin arbiter sharing one data-memory write port between ALU cores
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module alu_write_arbiter #(
  parameter int num_ports      = 4,
  parameter int mem_addr_width = 16,
  parameter int data_width     = `REG_WIDTH,
  parameter int idx_width      = $clog2(num_ports)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_ports-1:0]                     req_valid_i,
  input  logic [num_ports-1:0][mem_addr_width-1:0] req_addr_i,
  input  logic [num_ports-1:0][data_width-1:0]     req_data_i,
  output logic [num_ports-1:0]                     req_ready_o,
  output logic                                     mem_valid_o,
  output logic [mem_addr_width-1:0]                mem_addr_o,
  output logic [data_width-1:0]                    mem_data_o,
  output logic [idx_width-1:0]                     mem_port_o,
  input  logic                                     mem_ready_i,
  output logic                                     busy_o
);

  logic [num_ports-1:0]                     pend;
  logic [num_ports-1:0][mem_addr_width-1:0] pend_addr;
  logic [num_ports-1:0][data_width-1:0]     pend_data;
  logic [idx_width-1:0]                     last;

  logic                 out_free;
  logic                 grant_found;
  logic [idx_width-1:0] grant_idx;
  logic [idx_width-1:0] cand;

  // Ready depends only on holding-register state, so a port freed by a grant
  // accepts its next request one cycle later.
  assign req_ready_o = ~pend;
  assign out_free    = !mem_valid_o || mem_ready_i;
  assign busy_o      = (|pend) || mem_valid_o;

  // Search starts one past the previous winner and wraps, giving each port
  // at most num_ports-1 grants of wait while continuously pending.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= num_ports; k++) begin
      cand = idx_width'((int'(last) + k) % num_ports);
      if (!grant_found && pend[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend        <= '0;
      pend_addr   <= '0;
      pend_data   <= '0;
      last        <= idx_width'(num_ports - 1);
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_port_o  <= '0;
    end else begin
      for (int i = 0; i < num_ports; i++) begin
        if (req_valid_i[i] && !pend[i]) begin
          pend[i]      <= 1'b1;
          pend_addr[i] <= req_addr_i[i];
          pend_data[i] <= req_data_i[i];
        end
      end
      // A granted port always has pend set, so it never collides with the
      // acceptance above in the same cycle.
      if (out_free) begin
        if (grant_found) begin
          mem_valid_o     <= 1'b1;
          mem_addr_o      <= pend_addr[grant_idx];
          mem_data_o      <= pend_data[grant_idx];
          mem_port_o      <= grant_idx;
          pend[grant_idx] <= 1'b0;
          last            <= grant_idx;
        end else begin
          mem_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/alu_write_arbiter.md
# alu_write_arbiter

Round-robin arbiter that shares one data-memory write port between `num_ports` ALU cores. Each core's memory-write instruction result (address plus write data) enters a per-port one-entry holding register. The arbiter drains the holding registers to a single registered memory write channel using a valid/ready handshake. It sits between the ALU array and the data-memory write port of the shader cluster.

## Interface
Parameters:
- `num_ports`, default 4: number of requesting ALU cores; 2..16.
- `mem_addr_width`, default 16: width of a memory address; matches the ALU parameter of the same name.
- `data_width`, default `` `REG_WIDTH `` (32): width of one write word.
- `idx_width`, default `$clog2(num_ports)`: width of the port index; derived, do not override.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in `num_ports`: per-port write request.
- `req_addr_i` in `num_ports` x `mem_addr_width`: per-port write address.
- `req_data_i` in `num_ports` x `data_width`: per-port write data.
- `req_ready_o` out `num_ports`: per-port accept.
- `mem_valid_o` out 1: memory write valid.
- `mem_addr_o` out `mem_addr_width`: memory write address.
- `mem_data_o` out `data_width`: memory write data.
- `mem_port_o` out `idx_width`: index of the port that owns the current memory write.
- `mem_ready_i` in 1: memory accepts the write.
- `busy_o` out 1: high when any holding register or the output register is occupied.

## Operation
- Per port `i`:
  - Holding register holds `pend_addr[i]`, `pend_data[i]` and flag `pend[i]`.
  - `req_ready_o[i] = !pend[i]`. This is purely registered state, with no combinational path from any input.
  - A request is accepted when `req_valid_i[i] && req_ready_o[i]`. On acceptance: `pend[i] <= 1` and address/data are captured.
- Output register holds `mem_valid_o`, `mem_addr_o`, `mem_data_o` and `mem_port_o`.
  - It is free when `!mem_valid_o || mem_ready_i`.
- Arbitration happens every cycle the output register is free.
  - Search `pend` starting at `last + 1` and wrap modulo `num_ports`. The first set bit is the winner `g`.
  - If a winner exists: load the output register from port `g`, set `mem_valid_o <= 1`, clear `pend[g]`, set `last <= g`.
  - If there is no winner but the output register is being drained: `mem_valid_o <= 0`.
- The output register holds its contents unchanged while `mem_valid_o && !mem_ready_i`. Address, data and port are stable until accepted.
- A port cannot be granted and accept a new request in the same cycle, because `pend[g]` is still 1 at the acceptance test. The new request is accepted the following cycle.
- Only requests pending at the clock edge are eligible. A request accepted in cycle N is first eligible in cycle N+1.
- `busy_o = |pend || mem_valid_o`.
- Write ordering within one port is preserved, since each port has a single holding entry. Ordering across ports is round-robin, not request time.

## Timing
- Reset values:
  - All outputs: `pend = 0`, `mem_valid_o = 0`, `mem_addr_o = 0`, `mem_data_o = 0`, `mem_port_o = 0`, `busy_o = 0`, `req_ready_o = all 1`.
  - Internal: `last = num_ports-1`, so port 0 has first priority.
- Latency, with `mem_ready_i` held high and no contention: `req_valid_i` accepted at edge N; `mem_valid_o` high after edge N+1.
- Throughput:
  - The output drains one write per cycle when several ports are pending and `mem_ready_i = 1`.
  - A single port sustains one write every 2 cycles.
- Back-pressure: while `mem_ready_i = 0` and `mem_valid_o = 1`, no arbitration occurs. Holding registers fill and the corresponding `req_ready_o` bits go low.
- Fairness: a continuously pending port waits at most `num_ports-1` grants.
- Reset asserted mid-operation discards all pending and in-flight writes. The state is exactly the reset state at the next edge. `mem_valid_o` drops without a handshake, so memory must also be in reset.
- Wrap-around: after a grant to port `num_ports-1`, the search begins at port 0.

## Test plan
- Single write: port 2 sends addr 0x0040, data 0xDEADBEEF, with `mem_ready_i = 1`. Required: `mem_valid_o` high exactly 2 edges later with those values and `mem_port_o = 2`, then low the next cycle.
- All four ports request in the same cycle, with addr = 0x10·i and `mem_ready_i = 1`. Required: grants are issued in port order 0, 1, 2, 3 on 4 consecutive cycles, and `busy_o` falls the cycle after the last write.
- Back-pressure: port 1 write pending with `mem_ready_i = 0` for 5 cycles. Required: `mem_addr_o` and `mem_data_o` are stable; `req_ready_o[1]` is low once a second port-1 request is held; both writes complete in order after `mem_ready_i` rises.
- Round-robin wrap: `last = 3`, then ports 0 and 3 both pending. Required: port 0 is granted first, then port 3.
- Saturation: ports 0 and 1 assert `req_valid_i` continuously for 20 cycles with `mem_ready_i = 1`. Required: writes alternate between port 0 and port 1, and neither port waits more than 1 grant.
- Reset mid-stream: assert `reset_i` while 3 pending and `mem_valid_o = 1`. Required: at the next edge all outputs are at their reset values, and no stale write appears after reset deasserts.
